accum_seq_ctrl: RTL and testbench
=================================

ACCUM_SEQ_CTRL -- requirements
Module: accum_seq_ctrl

Interface
REQ-001 Parameter W, default 15, width of the x and y accumulators and result ports.
REQ-002 Parameter LIMIT, default 200, y bound at which stepping stops; LIMIT < 2^W.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  level request per requester; bit i belongs to requester i.
REQ-006 cnt0  input  8  step count for requester 0, sampled only at its grant edge.
REQ-007 cnt1  input  8  step count for requester 1, sampled only at its grant edge.
REQ-008 gnt  output  2  one-hot, one-cycle grant pulse.
REQ-009 busy  output  1  high while state is RUN or DONE.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_x  output  W  final x.
REQ-013 res_y  output  W  final y.
REQ-014 res_id  output  1  requester index of the result.
REQ-015 res_sat  output  1  run stopped on LIMIT before the count was exhausted.

Function
REQ-016 The block SHALL own one x/y accumulator datapath and time-share it between two requesters through a three-state FSM: IDLE, RUN, DONE.
REQ-017 IDLE: if any req bit is set at an edge (E0), the block SHALL pick a winner, load x=1, y=0, rem=cnt of winner, record id, enter RUN, and drive gnt[id]=1 for exactly the cycle after E0.
REQ-018 Arbitration SHALL be round-robin: single request wins outright; both requests -> grant the index different from the last granted; last-granted pointer updates at each grant.
REQ-019 RUN, each edge: if rem != 0 and y < LIMIT -> x <= x + y (mod 2^W), y <= y + 1, rem <= rem - 1; otherwise -> enter DONE and latch res_sat = (rem != 0).
REQ-020 Latency: with k = min(cnt, LIMIT), steps occur at edges E1..Ek and DONE is entered at E(k+1); cnt=0 enters DONE at E1 with x=1, y=0, res_sat=0.
REQ-021 DONE: res_valid=1; res_x, res_y, res_id, res_sat SHALL be stable until the edge where res_valid and res_ready are both high, then FSM returns to IDLE.
REQ-022 A new grant SHALL NOT occur in the same edge as the result handshake; earliest next grant is the edge after the return to IDLE.
REQ-023 req bits while busy SHALL be ignored (not queued); requesters hold req and cnt until their gnt pulse and drop req afterwards.
REQ-024 res_* outputs SHALL expose the live x, y, id while not in DONE; they are only meaningful when res_valid=1.
REQ-025 Invariant: in DONE, y == min(cnt, LIMIT), x == 1 + y(y-1)/2 mod 2^W, and res_sat=1 implies y == LIMIT and x >= y.
REQ-026 gnt SHALL never have both bits set; res_valid SHALL never be high outside DONE.

Reset
REQ-027 On rst at an edge: state=IDLE, x=1, y=0, rem=0, gnt=0, res_valid=0, res_sat=0, res_id=0, busy=0, last-granted pointer=1 (requester 0 wins first contention).
REQ-028 rst during RUN or DONE SHALL abort the run and discard the pending result with no handshake; rst has priority over every other event.

Verification
REQ-029 After reset, req=01, cnt0=5 -> gnt=01 one cycle; res_valid 6 edges after grant edge; res_x=11, res_y=5, res_id=0, res_sat=0.
REQ-030 req=10, cnt1=255 -> res_y=200, res_x=19901, res_sat=1, res_id=1; res_valid 201 edges after grant edge.
REQ-031 req=11 held across three consecutive jobs (cnt0=cnt1=3, res_ready=1) -> grants alternate 0,1,0; each result res_x=4, res_y=3.
REQ-032 cnt0=0 -> res_valid at E1 with res_x=1, res_y=0, res_sat=0; res_ready held low 10 cycles -> outputs unchanged, no new gnt despite req=10.
REQ-033 rst asserted mid-RUN (cnt0=100, after 40 steps) -> next cycle busy=0, res_valid=0, x=1, y=0; following req=11 -> gnt=01.
REQ-034 Random req/cnt/res_ready stream -> REQ-025 and REQ-026 hold every cycle; no grant while busy.

Source files
------------

// File: rtl/accum_seq_ctrl.sv
// Round-robin arbiter in front of one shared x/y accumulator. A granted requester runs
// up to cnt steps of (x += y, y++), bounded by y reaching LIMIT, then holds the result.
module accum_seq_ctrl #(
    parameter int unsigned W     = 15,
    parameter int unsigned LIMIT = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_i,
    input  logic [7:0]   cnt0_i,
    input  logic [7:0]   cnt1_i,
    output logic [1:0]   gnt_o,
    output logic         busy_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [W-1:0] res_x_o,
    output logic [W-1:0] res_y_o,
    output logic         res_id_o,
    output logic         res_sat_o
);

    localparam logic [W-1:0] LimitW = W'(LIMIT);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [7:0]   rem_q, rem_d;
    logic         id_q, id_d;
    logic         sat_q, sat_d;
    logic         last_q, last_d;
    logic [1:0]   gnt_q, gnt_d;
    logic         win;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rem_d   = rem_q;
        id_d    = id_q;
        sat_d   = sat_q;
        last_d  = last_q;
        gnt_d   = 2'b00;
        win     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i != 2'b00) begin
                    // Under contention the pointer hands the grant to the other requester.
                    win     = (req_i == 2'b11) ? ~last_q : req_i[1];
                    last_d  = win;
                    id_d    = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    x_d     = W'(1);
                    y_d     = '0;
                    rem_d   = win ? cnt1_i : cnt0_i;
                    sat_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rem_q != 8'd0 && y_q < LimitW) begin
                    x_d   = x_q + y_q;
                    y_d   = y_q + W'(1);
                    rem_d = rem_q - 8'd1;
                end else begin
                    sat_d   = (rem_q != 8'd0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= W'(1);
            y_q     <= '0;
            rem_q   <= 8'd0;
            id_q    <= 1'b0;
            sat_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            sat_q   <= sat_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign busy_o      = (state_q == StRun) || (state_q == StDone);
    assign res_valid_o = (state_q == StDone);
    assign res_x_o     = x_q;
    assign res_y_o     = y_q;
    assign res_id_o    = id_q;
    assign res_sat_o   = sat_q;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed and random checks of accum_seq_ctrl: arbitration, step latency, LIMIT
// saturation, result hold under back-pressure and reset abort.
module tb_accum_seq_ctrl;

    localparam int W     = 15;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [7:0]   cnt0, cnt1;
    logic [1:0]   gnt;
    logic         busy, res_valid, res_ready;
    logic [W-1:0] res_x, res_y;
    logic         res_id, res_sat;

    int total = 0;
    int bad   = 0;

    accum_seq_ctrl #(.W(W), .LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .cnt0_i      (cnt0),
        .cnt1_i      (cnt1),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_x_o     (res_x),
        .res_y_o     (res_y),
        .res_id_o    (res_id),
        .res_sat_o   (res_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; cnt0 = 8'd0; cnt1 = 8'd0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
        total++; if (res_x !== 15'd1 || res_y !== 15'd0) begin
            bad++; $display("FAIL reset_xy got=%0d,%0d want=1,0", res_x, res_y); end
        total++; if (res_id !== 1'b0 || res_sat !== 1'b0) begin
            bad++; $display("FAIL reset_id_sat got=%b,%b want=0,0", res_id, res_sat); end
    endtask

    task automatic test_single();
        int n;
        req = 2'b01; cnt0 = 8'd5; res_ready = 1'b0;
        tick();
        req = 2'b00;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b want=01", gnt); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (n == 1) begin
                total++; if (gnt !== 2'b00) begin bad++; $display("FAIL single_gnt_pulse got=%b want=00", gnt); end
            end
            if (res_valid) break;
        end
        total++; if (n != 6 || res_valid !== 1'b1) begin
            bad++; $display("FAIL single_latency got=%0d want=6", n); end
        total++; if (res_x !== 15'd11 || res_y !== 15'd5 || res_id !== 1'b0 || res_sat !== 1'b0) begin
            bad++; $display("FAIL single_result got=x%0d y%0d id%b sat%b want=x11 y5 id0 sat0",
                            res_x, res_y, res_id, res_sat); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL single_handshake got=v%b b%b want=v0 b0", res_valid, busy); end
    endtask

    task automatic test_saturate();
        int n;
        req = 2'b10; cnt1 = 8'd255; res_ready = 1'b0;
        tick();
        req = 2'b00;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL sat_gnt got=%b want=10", gnt); end
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick(); n++;
            if (res_valid) break;
        end
        total++; if (n != 201 || res_valid !== 1'b1) begin
            bad++; $display("FAIL sat_latency got=%0d want=201", n); end
        total++; if (res_x !== 15'd19901 || res_y !== 15'd200 || res_id !== 1'b1 || res_sat !== 1'b1) begin
            bad++; $display("FAIL sat_result got=x%0d y%0d id%b sat%b want=x19901 y200 id1 sat1",
                            res_x, res_y, res_id, res_sat); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [3];
        bit found;
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
        req = 2'b11; cnt0 = 8'd3; cnt1 = 8'd3; res_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            found = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (gnt != 2'b00) begin found = 1; break; end
            end
            total++; if (!found || gnt !== want[j]) begin
                bad++; $display("FAIL rr_gnt%0d got=%b want=%b", j, gnt, want[j]); end
            found = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (res_valid) begin found = 1; break; end
            end
            total++; if (!found || res_x !== 15'd4 || res_y !== 15'd3 || res_id !== want[j][1]) begin
                bad++; $display("FAIL rr_result%0d got=x%0d y%0d id%b want=x4 y3 id%b",
                                j, res_x, res_y, res_id, want[j][1]); end
            tick();
            total++; if (busy !== 1'b0 || gnt !== 2'b00) begin
                bad++; $display("FAIL rr_idle%0d got=b%b g%b want=b0 g00", j, busy, gnt); end
        end
        req = 2'b00; res_ready = 1'b0;
        tick();
    endtask

    task automatic test_zero_hold();
        bit found;
        req = 2'b01; cnt0 = 8'd0; cnt1 = 8'd7; res_ready = 1'b0;
        tick();
        req = 2'b10;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL zero_gnt got=%b want=01", gnt); end
        tick();
        total++; if (res_valid !== 1'b1 || res_x !== 15'd1 || res_y !== 15'd0 || res_sat !== 1'b0) begin
            bad++; $display("FAIL zero_result got=v%b x%0d y%0d sat%b want=v1 x1 y0 sat0",
                            res_valid, res_x, res_y, res_sat); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b1 || res_x !== 15'd1 || res_y !== 15'd0 || res_id !== 1'b0 ||
                gnt !== 2'b00) begin
                bad++; $display("FAIL zero_hold%0d got=v%b x%0d y%0d id%b g%b want=v1 x1 y0 id0 g00",
                                i, res_valid, res_x, res_y, res_id, gnt); end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || gnt !== 2'b00) begin
            bad++; $display("FAIL zero_no_same_edge_gnt got=v%b g%b want=v0 g00", res_valid, gnt); end
        tick();
        req = 2'b00;
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL zero_next_gnt got=%b want=10", gnt); end
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid) begin found = 1; break; end
        end
        total++; if (!found || res_x !== 15'd22 || res_y !== 15'd7 || res_id !== 1'b1) begin
            bad++; $display("FAIL zero_followup got=x%0d y%0d id%b want=x22 y7 id1", res_x, res_y, res_id); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_abort();
        bit found;
        req = 2'b01; cnt0 = 8'd100; res_ready = 1'b0;
        tick();
        req = 2'b00;
        for (int i = 0; i < 40; i++) tick();
        total++; if (res_y !== 15'd40 || res_x !== 15'd781 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_mid got=x%0d y%0d b%b want=x781 y40 b1", res_x, res_y, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || res_valid !== 1'b0 || res_x !== 15'd1 || res_y !== 15'd0) begin
            bad++; $display("FAIL abort_reset got=b%b v%b x%0d y%0d want=b0 v0 x1 y0",
                            busy, res_valid, res_x, res_y); end
        req = 2'b11; cnt1 = 8'd9;
        tick();
        req = 2'b00;
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL abort_regrant got=%b want=01", gnt); end
        found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (res_valid) begin found = 1; break; end
        end
        total++; if (!found || res_x !== 15'd4951 || res_y !== 15'd100 || res_sat !== 1'b0) begin
            bad++; $display("FAIL abort_followup got=x%0d y%0d sat%b want=x4951 y100 sat0",
                            res_x, res_y, res_sat); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        int exp_cnt, ey, ex;
        logic [7:0] c0, c1;
        logic prev_busy;
        rst = 1'b1; tick(); rst = 1'b0;
        prev_busy = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            c0 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            c1 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            req = 2'($urandom_range(0, 3)); cnt0 = c0; cnt1 = c1;
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (gnt == 2'b01) exp_cnt = int'(c0);
            if (gnt == 2'b10) exp_cnt = int'(c1);
            total++; if (gnt === 2'b11) begin bad++; $display("FAIL rnd_gnt_onehot cyc=%0d got=%b", i, gnt); end
            total++; if (gnt != 2'b00 && prev_busy) begin
                bad++; $display("FAIL rnd_gnt_busy cyc=%0d got=%b want=00", i, gnt); end
            total++; if (res_valid && !busy) begin
                bad++; $display("FAIL rnd_valid_busy cyc=%0d got=b%b want=b1", i, busy); end
            if (res_valid) begin
                ey = (exp_cnt < LIMIT) ? exp_cnt : LIMIT;
                ex = (1 + (ey * (ey - 1)) / 2) % (1 << W);
                total++;
                if (int'(res_y) != ey || int'(res_x) != ex || res_sat !== (exp_cnt > LIMIT)) begin
                    bad++; $display("FAIL rnd_result cyc=%0d got=x%0d y%0d sat%b want=x%0d y%0d sat%b",
                                    i, res_x, res_y, res_sat, ex, ey, exp_cnt > LIMIT); end
            end
            prev_busy = busy;
        end
        req = 2'b00; res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_back_to_back();
        test_zero_hold();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
